// File: rtl/mailbox_mux_pkg.sv
// -----------------------------------------------------------------------------
// mailbox_pkg
// Shared definitions for the mailbox_mux block:
//   clog2_min1()  - channel tag width helper (never returns less than 1)
//   MBOX_CNT_W    - width of the output transfer counter
//   mbox_word_t   - tagged output word at the default geometry; the top
//                   re-declares it locally with its own parameter widths.
// -----------------------------------------------------------------------------
package mailbox_pkg;

    localparam int MBOX_CNT_W      = 32;
    localparam int MBOX_DEF_DATA_W = 32;
    localparam int MBOX_DEF_ID_W   = 2;

    // A single channel still needs a 1-bit tag so out_chan has a legal width.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MBOX_DEF_ID_W-1:0]   chan;
        logic [MBOX_DEF_DATA_W-1:0] data;
    } mbox_word_t;

endpackage

// File: rtl/mailbox_mux_fifo.sv
// -----------------------------------------------------------------------------
// mbox_fifo
// Synchronous single-clock FIFO used once per mailbox channel.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push_i, push_data_i - write request/data (ignored while full)
//   pop_i             - read request (caller only pops when level_o != 0)
//   pop_data_o        - head-of-queue word (valid while level_o != 0)
//   full_o            - level_o == DEPTH
//   level_o           - registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mbox_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;

    // Fullness is tracked by the level counter; pointers just wrap.
    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign push_ok    = push_i && !full_o;
    assign pop_data_o = mem_q[rptr_q];
    assign level_o    = level_q;

    always_comb begin
        wptr_d  = wptr_q + PTR_W'(push_ok);
        rptr_d  = rptr_q + PTR_W'(pop_i);
        level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: nothing is read while level is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mailbox_mux.sv
// -----------------------------------------------------------------------------
// mailbox_mux
// N-channel mailbox: each producer channel feeds its own FIFO; a round-robin
// arbiter drains the FIFOs into one registered, channel-tagged output stream.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid/in_ready/in_data - per-channel producer handshake; channel i
//                  payload at in_data[i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data/out_chan - tagged consumer stream
//   level        - per-channel FIFO occupancy, LVL_W bits each
//   xfer_count   - completed output transfers
// Optional feature: define MAILBOX_MUX_STATS_EN to build the transfer counter;
// otherwise xfer_count is tied to zero.
// -----------------------------------------------------------------------------
module mailbox_mux
    import mailbox_pkg::*;
#(
    parameter int  NUM_CHAN = 4,
    parameter int  DATA_W   = 32,
    parameter int  DEPTH    = 8,
    localparam int ID_W     = clog2_min1(NUM_CHAN),
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CHAN-1:0]       in_valid,
    output logic [NUM_CHAN-1:0]       in_ready,
    input  logic [NUM_CHAN*DATA_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_chan,
    output logic [NUM_CHAN*LVL_W-1:0] level,
    output logic [MBOX_CNT_W-1:0]     xfer_count
);

    typedef struct packed {
        logic [ID_W-1:0]   chan;
        logic [DATA_W-1:0] data;
    } mbox_word_t;

    logic [NUM_CHAN-1:0][DATA_W-1:0] fifo_rdata;
    logic [NUM_CHAN-1:0][LVL_W-1:0]  fifo_level;
    logic [NUM_CHAN-1:0]             fifo_full;
    logic [NUM_CHAN-1:0]             fifo_pop;

    mbox_word_t      out_word_q, out_word_d;
    logic            out_valid_q, out_valid_d;
    logic [ID_W-1:0] rr_q, rr_d;

    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic            load_en;
    logic            do_load;
    int              cand;

    // ---------------- per-channel FIFOs ----------------
    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        mbox_fifo #(
            .DEPTH (DEPTH),
            .DATA_W(DATA_W),
            .LVL_W (LVL_W)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (in_valid[i]),
            .push_data_i(in_data[i*DATA_W +: DATA_W]),
            .pop_i      (fifo_pop[i]),
            .pop_data_o (fifo_rdata[i]),
            .full_o     (fifo_full[i]),
            .level_o    (fifo_level[i])
        );
        // Ready reflects fullness only, so a same-cycle pop never opens it.
        assign in_ready[i] = !fifo_full[i];
        assign fifo_pop[i] = do_load && (grant_idx == ID_W'(i));
    end

    assign level = fifo_level;

    // ---------------- round-robin arbiter ----------------
    // Scan upward from rr (mod NUM_CHAN); first non-empty FIFO wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            cand = (int'(rr_q) + k) % NUM_CHAN;
            if (!grant_vld && (fifo_level[cand] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    // Refill when the register is empty or its word leaves this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign do_load = load_en && grant_vld;

    // ---------------- output register ----------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        rr_d        = rr_q;
        if (do_load) begin
            out_valid_d     = 1'b1;
            out_word_d.chan = grant_idx;
            out_word_d.data = fifo_rdata[grant_idx];
            rr_d            = (grant_idx == ID_W'(NUM_CHAN - 1)) ? '0 : grant_idx + 1'b1;
        end else if (load_en) begin
            // Nothing to load: the held word (if any) was consumed.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            rr_q        <= rr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_word_q.data;
    assign out_chan  = out_word_q.chan;

    // ---------------- transfer statistics ----------------
`ifdef MAILBOX_MUX_STATS_EN
    logic [MBOX_CNT_W-1:0] xfer_q, xfer_d;

    // Wraps naturally at 2^32.
    assign xfer_d = xfer_q + MBOX_CNT_W'(out_valid_q && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_q <= '0;
        end else begin
            xfer_q <= xfer_d;
        end
    end

    assign xfer_count = xfer_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_mailbox_mux.sv
// -----------------------------------------------------------------------------
// tb_mailbox_mux
// Scoreboard bench for mailbox_mux. A queue-based reference model advances
// once per clock from the driven inputs; loaded output words are pushed into
// an expected queue that a separate monitor drains on each output handshake.
// -----------------------------------------------------------------------------
module tb_mailbox_mux;

    localparam int NC    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_ready;
    logic [NC*DW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IDW-1:0]    out_chan;
    logic [NC*LW-1:0]  level;
    logic [31:0]       xfer_count;

    mailbox_mux #(.NUM_CHAN(NC), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .level     (level),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    typedef struct {
        int          chan;
        logic [31:0] data;
    } exp_t;

    logic [DW-1:0] mq [NC][$];   // FIFO contents per channel
    exp_t          expq[$];      // words loaded into the output register
    int            m_ov;
    int            m_rr;
    int unsigned   m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*DW-1:0] rnd_data();
        logic [NC*DW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    // Compare DUT state (just after an edge) against the model.
    task automatic check_state();
        logic [31:0] exp_cnt;
`ifdef MAILBOX_MUX_STATS_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("level[%0d]", i), level[i*LW +: LW], mq[i].size());
            chk($sformatf("in_ready[%0d]", i), in_ready[i], (mq[i].size() != DEPTH));
        end
        chk("out_valid", out_valid, m_ov);
        chk("xfer_count", xfer_count, exp_cnt);
    endtask

    // Advance the model across the next edge using the driven inputs.
    task automatic model_step();
        int   sz[NC];
        int   g;
        bit   load;
        exp_t e;
        if (rst) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            expq.delete();
            m_ov  = 0;
            m_rr  = 0;
            m_cnt = 0;
            return;
        end
        if (m_ov != 0 && out_ready) m_cnt++;
        for (int i = 0; i < NC; i++) sz[i] = mq[i].size();
        load = (m_ov == 0) || out_ready;
        g = -1;
        for (int k = 0; k < NC; k++) begin
            int c;
            c = (m_rr + k) % NC;
            if (g < 0 && sz[c] > 0) g = c;
        end
        if (load && g >= 0) begin
            e.chan = g;
            e.data = mq[g].pop_front();
            expq.push_back(e);
            m_ov = 1;
            m_rr = (g + 1) % NC;
        end else if (load) begin
            m_ov = 0;
        end
        for (int i = 0; i < NC; i++)
            if (in_valid[i] && sz[i] < DEPTH) mq[i].push_back(in_data[i*DW +: DW]);
    endtask

    task automatic drive(input logic r, input logic [NC-1:0] v,
                         input logic [NC*DW-1:0] d, input logic orr);
        @(posedge clk);
        #1;
        check_state();
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = orr;
        model_step();
    endtask

    // ---------------- monitor ----------------
    logic           p_ov = 1'b0, p_hs = 1'b0;
    logic [DW-1:0]  p_data = '0;
    logic [IDW-1:0] p_chan = '0;

    always @(negedge clk) begin
        exp_t e;
        // A word stalled by backpressure must not change.
        if (!rst && p_ov && !p_hs && out_valid) begin
            chk("hold_data", out_data, p_data);
            chk("hold_chan", out_chan, p_chan);
        end
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got chan %0d data %0h expected none", out_chan, out_data);
            end else begin
                e = expq.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_chan", out_chan, e.chan);
            end
        end
        p_ov   = out_valid && !rst;
        p_hs   = out_valid && out_ready;
        p_data = out_data;
        p_chan = out_chan;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NC*DW-1:0] d;
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        model_step();
        repeat (3) drive(1, '0, '0, 0);

        // Single word on ch2: visible two edges after the push.
        d = '0;
        d[2*DW +: DW] = 32'hA5A5_0001;
        drive(0, 4'b0100, d, 1);
        repeat (4) drive(0, '0, rnd_data(), 1);

        // Round robin: two words per channel, then drain.
        repeat (2) drive(0, 4'hF, rnd_data(), 0);
        repeat (10) drive(0, '0, rnd_data(), 1);

        // Reset mid-burst with words buffered in ch1.
        repeat (4) drive(0, 4'b0010, rnd_data(), 0);
        drive(1, 4'hF, rnd_data(), 1);
        repeat (2) drive(0, '0, rnd_data(), 0);

        // Fill ch0 past DEPTH, release one pop, then stall again.
        repeat (12) drive(0, 4'b0001, rnd_data(), 0);
        drive(0, 4'b0001, rnd_data(), 1);
        repeat (3) drive(0, 4'b0001, rnd_data(), 0);
        repeat (14) drive(0, '0, rnd_data(), 1);

        // Backpressure while ch3 keeps pushing.
        repeat (6) drive(0, 4'b1000, rnd_data(), 0);
        repeat (10) drive(0, '0, rnd_data(), 1);

        // ch1 to level 4, then push and pop together.
        repeat (5) drive(0, 4'b0010, rnd_data(), 0);
        drive(0, 4'b0010, rnd_data(), 1);
        repeat (8) drive(0, '0, rnd_data(), 1);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic orr;
            orr = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 299) == 0), NC'($urandom), rnd_data(), orr);
        end

        // Drain and confirm nothing is left outstanding.
        repeat (40) drive(0, '0, rnd_data(), 1);
        @(posedge clk);
        #1;
        check_state();
        chk("expq_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
